// File: rtl/credit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_pkg                                                                 |
// | Shared types and helpers for the credit-based link sender/receiver pair.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package credit_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        WAIT_RX = 2'd1,
        ACTIVE  = 2'd2
    } sender_state_e;

    // Bits needed to hold every count from 0 up to and including max_credits.
    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_counter                                                             |
// | Saturating credit counter with load/clear and an overflow indication.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module credit_counter
    import credit_pkg::*;
#(
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = credit_width(MAX_CREDITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          incr,
    input  logic          decr,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] c_max_credits      = CW'(MAX_CREDITS);
    localparam logic [CW:0]   c_max_credits_wide = (CW+1)'(MAX_CREDITS);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_sat;

    // One extra bit so a return at full count is visible before saturating.
    always_comb begin
        w_sum = {1'b0, r_count} + {{CW{1'b0}}, incr} - {{CW{1'b0}}, decr};
        w_sat = (w_sum > c_max_credits_wide) ? c_max_credits_wide : w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else begin
            r_count <= w_sat[CW-1:0];
        end
    end

    assign count    = r_count;
    assign overflow = incr & ~decr & ~clear & ~load & (r_count == c_max_credits);

endmodule
`default_nettype wire

// File: rtl/credit_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_sender                                                              |
// | Sender side of a credit-based link: ready/valid intake, 1-cycle forward.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module credit_sender
    import credit_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = credit_width(MAX_CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_credit,
    output logic                  pop_credit_stall,
    output logic                  pop_sender_in_reset,
    input  logic                  pop_receiver_in_reset,
    input  logic [CW-1:0]         credit_initial,
    input  logic [CW-1:0]         credit_withhold,
    output logic [CW-1:0]         credit_count,
    output logic                  credit_available,
    output logic                  credit_overflow_err
);

    localparam logic [CW-1:0] c_max_credits = CW'(MAX_CREDITS);

    sender_state_e         r_state;
    sender_state_e         w_state_next;
    logic                  w_ready;
    logic                  w_stall;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_incr;
    logic                  w_accept;
    logic                  w_available;
    logic                  w_ovf_pulse;
    logic [CW-1:0]         w_count;
    logic                  r_pop_valid;
    logic [DATA_WIDTH-1:0] r_pop_data;
    logic                  r_sender_in_reset;
    logic                  r_overflow_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_stall      = 1'b1;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            RESET: begin
                w_state_next = WAIT_RX;
            end
            WAIT_RX: begin
                if (!pop_receiver_in_reset) begin
                    w_state_next = ACTIVE;
                    w_load       = 1'b1;
                end
            end
            ACTIVE: begin
                w_ready = w_available & ~pop_receiver_in_reset;
                w_stall = (w_count == c_max_credits);
                // Far side went into reset: forget all credits, they get reissued.
                if (pop_receiver_in_reset) begin
                    w_state_next = WAIT_RX;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = RESET;
            end
        endcase
    end

    assign w_available = (w_count > credit_withhold);
    assign w_accept    = push_valid & w_ready;
    assign w_incr      = pop_credit & (r_state == ACTIVE);

    credit_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_value (credit_initial),
        .incr       (w_incr),
        .decr       (w_accept),
        .clear      (w_clear),
        .count      (w_count),
        .overflow   (w_ovf_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sender_in_reset <= 1'b1;
            r_pop_valid       <= 1'b0;
            r_pop_data        <= '0;
            r_overflow_err    <= 1'b0;
        end else begin
            r_sender_in_reset <= 1'b0;
            r_pop_valid       <= w_accept;
            if (w_accept) begin
                r_pop_data <= push_data;
            end
            if (w_ovf_pulse) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign push_ready          = w_ready;
    assign pop_credit_stall    = w_stall;
    assign pop_valid           = r_pop_valid;
    assign pop_data            = r_pop_data;
    assign pop_sender_in_reset = r_sender_in_reset;
    assign credit_count        = w_count;
    assign credit_available    = w_available;
    assign credit_overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_credit_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_credit_sender                                                           |
// | Vector table plus data scoreboard for credit_sender (MAX_CREDITS=4).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_credit_sender;

    localparam int DW = 8;
    localparam int CW = 3;
    localparam int NV = 24;

    logic          clk;
    logic          rst_n;
    logic          push_ready;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_credit;
    logic          pop_credit_stall;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic          credit_available;
    logic          credit_overflow_err;

    credit_sender #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (4)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .push_ready            (push_ready),
        .push_valid            (push_valid),
        .push_data             (push_data),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .pop_credit            (pop_credit),
        .pop_credit_stall      (pop_credit_stall),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_overflow_err   (credit_overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          pv;
        logic          pc;
        logic          rxr;
        logic [CW-1:0] wh;
        logic [DW-1:0] d;
        logic          e_ready;
        logic [CW-1:0] e_cnt;
        logic          e_stall;
        logic          e_ovf;
    } vec_t;

    vec_t          vecs[NV];
    logic [DW-1:0] sb_q[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic          e_valid;
        logic [DW-1:0] e_data;

        vecs = '{
            // pv    pc    rxr   wh    d        ready cnt   stall ovf
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0}, // receiver still in reset
            '{1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0}, // link up, load 3
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hA1, 1'b1, 3'd2, 1'b0, 1'b0}, // burst
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hA2, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hA3, 1'b1, 3'd0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hA4, 1'b0, 3'd0, 1'b0, 1'b0}, // out of credits
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 3'd0, 8'hB1, 1'b1, 3'd1, 1'b0, 1'b0}, // accept + return
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd2, 8'hC0, 1'b0, 3'd2, 1'b0, 1'b0}, // withhold blocks
            '{1'b1, 1'b0, 1'b0, 3'd1, 8'hC1, 1'b1, 3'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd1, 8'hC2, 1'b0, 3'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0}, // fill up
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1}, // overflow
            '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hD1, 1'b1, 3'd3, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1, 3'd0, 8'hD2, 1'b0, 3'd0, 1'b1, 1'b1}, // far reset mid-burst
            '{1'b1, 1'b1, 1'b1, 3'd0, 8'hD3, 1'b0, 3'd0, 1'b1, 1'b1}, // returns ignored
            '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1}, // reload
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'hE1, 1'b1, 3'd2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1}
        };

        rst_n                 = 1'b0;
        push_valid            = 1'b0;
        push_data             = '0;
        pop_credit            = 1'b0;
        pop_receiver_in_reset = 1'b1;
        credit_initial        = 3'd3;
        credit_withhold       = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(credit_count), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_ovf", 32'(credit_overflow_err), 32'd0);
        check("rst_sender_in_reset", 32'(pop_sender_in_reset), 32'd1);
        check("rst_ready", 32'(push_ready), 32'd0);
        check("rst_stall", 32'(pop_credit_stall), 32'd1);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("sender_in_reset_drop", 32'(pop_sender_in_reset), 32'd1 - 32'd1);
        check("wait_count", 32'(credit_count), 32'd0);

        for (int i = 0; i < NV; i++) begin
            push_valid            = vecs[i].pv;
            push_data             = vecs[i].d;
            pop_credit            = vecs[i].pc;
            pop_receiver_in_reset = vecs[i].rxr;
            credit_withhold       = vecs[i].wh;
            #1;
            check($sformatf("v%0d_ready", i), 32'(push_ready), 32'(vecs[i].e_ready));
            e_valid = vecs[i].pv & vecs[i].e_ready;
            if (e_valid) sb_q.push_back(vecs[i].d);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pop_valid", i), 32'(pop_valid), 32'(e_valid));
            if (e_valid) begin
                e_data = sb_q.pop_front();
                check($sformatf("v%0d_pop_data", i), 32'(pop_data), 32'(e_data));
            end
            check($sformatf("v%0d_count", i), 32'(credit_count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_stall", i), 32'(pop_credit_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_ovf", i), 32'(credit_overflow_err), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_avail", i), 32'(credit_available),
                  32'(vecs[i].e_cnt > vecs[i].wh));
            check($sformatf("v%0d_sender_in_reset", i), 32'(pop_sender_in_reset), 32'd0);
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d words expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/credit_sender.md
Name: credit_sender

Overview:
- Upstream partner of the credit receiver: sits on the sender side of a credit-based link.
- Holds the credit count and accepts data from a local producer over a ready/valid interface, only while a credit is available.
- Forwards accepted data to the receiver with one cycle of latency.
- Returns-credit pulses from the receiver replenish the count.
- Resets of the local side and the far side are exchanged so neither side sends into a link that is resetting.

Parameters:
- DATA_WIDTH, 8, width of the payload.
- MAX_CREDITS, 4, largest credit count the sender can hold; must be at least 1.
- CW, $clog2(MAX_CREDITS+1), width of credit counters (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_ready  out  1  the sender can accept a word this cycle
- push_valid  in  1  the local producer offers a word
- push_data  in  DATA_WIDTH  the producer's word
- pop_valid  out  1  the word on pop_data is valid toward the receiver
- pop_data  out  DATA_WIDTH  the word sent to the receiver
- pop_credit  in  1  credit-return pulse from the receiver; one credit per cycle
- pop_credit_stall  out  1  asks the receiver to hold credit returns
- pop_sender_in_reset  out  1  the sender is in reset
- pop_receiver_in_reset  in  1  the receiver is in reset
- credit_initial  in  CW  credit count loaded when the link comes up; must be ≤ MAX_CREDITS and held static
- credit_withhold  in  CW  number of credits kept in reserve and never spent
- credit_count  out  CW  current number of credits
- credit_available  out  1  credit_count > credit_withhold
- credit_overflow_err  out  1  sticky flag: a credit was returned while the count was full

Behaviour:
- Reset (rst_n low, asynchronous): state RESET.
  - credit_count=0, pop_valid=0, pop_data=0, credit_overflow_err=0.
  - pop_sender_in_reset=1.
  - push_ready=0 and pop_credit_stall=1, both combinational from the state.
- State machine:
  - RESET -> WAIT_RX on the first clk edge after rst_n rises.
  - pop_sender_in_reset is registered and is high in RESET only; it drops on that edge.
  - WAIT_RX: while pop_receiver_in_reset=1, stay. The first edge that samples it low moves to ACTIVE and loads credit_count <= credit_initial.
  - ACTIVE: if pop_receiver_in_reset goes high, return to WAIT_RX on the next edge.
    - Clear credit_count to 0 and pop_valid to 0.
    - In-flight data is dropped.
- push_ready = (state==ACTIVE) & credit_available & ~pop_receiver_in_reset.
  - push_ready is combinational and does not depend on push_valid.
- Accept = push_valid & push_ready.
  - pop_valid <= accept.
  - pop_data <= push_data on accept; otherwise pop_data holds its value.
  - Latency is exactly 1 cycle; throughput is 1 word per cycle while credits last.
- Credit update in ACTIVE: next = count + pop_credit - accept, with all arithmetic in CW+1 bits.
  - A credit return and an accept in the same cycle leave the count unchanged.
  - Overflow: if the count is MAX_CREDITS, pop_credit=1 and accept=0, the count saturates at MAX_CREDITS and credit_overflow_err is set. The flag clears only on rst_n.
  - A count of 0 is never decremented, because credit_available=0 forces push_ready=0.
- pop_credit_stall = (state!=ACTIVE) | (credit_count==MAX_CREDITS).
- pop_credit is ignored outside ACTIVE.
- credit_withhold may change at any time and takes effect combinationally.
  - If credit_withhold ≥ credit_count, no data is sent.

Decomposition:
- Shared package credit_pkg:
  - sender_state_e enum {RESET, WAIT_RX, ACTIVE};
  - credit width helper function;
  - a common DATA_WIDTH default.
- One sub-module, credit_counter:
  - inputs: load, load value, increment, decrement, clear;
  - outputs: count and overflow;
  - saturates at MAX_CREDITS;
  - reused by future receiver-side counters.
- The FSM, the handshake logic and the data register stay in credit_sender.

Test Plan:
- Startup: hold rst_n low, then release with pop_receiver_in_reset=1 for 3 cycles, then drop it, with credit_initial=3.
  - pop_sender_in_reset goes low 1 cycle after rst_n release.
  - credit_count=3 one cycle after the receiver leaves reset.
  - push_ready goes high.
- Burst: credit_initial=3, credit_withhold=0, push_valid held high, no returns.
  - Exactly 3 words are accepted on consecutive cycles.
  - pop_valid follows each accept by 1 cycle with matching data.
  - credit_count steps 3→2→1→0 and push_ready=0 afterwards.
- Simultaneous: count=1, then accept and pop_credit in the same cycle.
  - Count stays 1.
  - Next cycle, pop_credit alone -> count 2.
- Withhold: count=2, credit_withhold=2 -> push_ready=0. Set credit_withhold=1 -> exactly 1 word is accepted, after which the count is 1.
- Overflow: MAX_CREDITS=4, count=4, pop_credit=1 with no accept.
  - Count stays 4.
  - credit_overflow_err=1 and stays set.
  - pop_credit_stall=1 throughout.
- Far reset mid-burst: raise pop_receiver_in_reset while pop_valid=1.
  - Next cycle: pop_valid=0, credit_count=0, push_ready=0, pop_credit_stall=1.
  - After release the count reloads from credit_initial.
